adder_nbit_seq: RTL and testbench

Parametrised, multi-cycle ripple-chunk adder/subtractor. It is the sequential successor to the fixed 16-bit combinational adder. Operands are latched on a start pulse and summed CHUNK bits per clock, with the carry held in a register between chunks. Results appear after WIDTH/CHUNK cycles with unsigned carry-out and signed-overflow flags. It sits in datapath blocks where a wide adder would not meet timing or area, and reports completion through a start/busy/done handshake.

---
 rtl/adder_nbit_seq.sv | 137 +++++++++++++
 tb/tb_adder_nbit_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_nbit_seq.sv
// Multi-cycle chunked adder/subtractor: WIDTH-bit add done CHUNK bits per clock with a registered carry.
// Latency: start accepted at edge E0, results loaded at edge E(NCHUNK); done pulses for one cycle after that.
// Backpressure: none; start is only sampled in IDLE or DONE and is ignored while busy.
module adder_nbit_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Reject parameter combinations the chunk slicing cannot represent.
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("adder_nbit_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;       // already inverted in subtract mode
    logic              carry_q;
    logic [WIDTH-1:0]  acc_q;     // partial result, filled one chunk per RUN cycle
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_out_q;
    logic              overflow_q;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  s_chunk;
    logic              c_chunk;
    logic              msb_cin;
    logic [WIDTH-1:0]  acc_d;
    logic              last_chunk;

    // Select the active chunk and place its partial sum into the accumulator image.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Sum bit = a ^ b ^ cin, so the carry into the chunk's top bit falls out directly.
        msb_cin    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
        last_chunk = (idx_q == IDXW'(NCHUNK - 1));
        acc_d      = acc_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                acc_d[i*CHUNK +: CHUNK] = s_chunk;
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : carry_in;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    carry_q <= c_chunk;
                    acc_q   <= acc_d;
                    if (last_chunk) begin
                        sum_q       <= acc_d;
                        carry_out_q <= c_chunk;
                        overflow_q  <= msb_cin ^ c_chunk;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Directed bench for adder_nbit_seq: default 16/4 instance plus 32/8 and 32/32 instances.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Every wait on done is bounded by a cycle budget.
module tb_adder_nbit_seq;

    logic        clk;
    logic        rst;

    logic        start;
    logic [15:0] a, b;
    logic        carry_in, sub;
    logic        busy, done;
    logic [15:0] sum;
    logic        carry_out, overflow;

    logic        start8, start32;
    logic [31:0] a32, b32;
    logic        cin32, sub32;
    logic        busy8, done8, co8, ov8;
    logic [31:0] sum8;
    logic        busy32, done32, co32, ov32;
    logic [31:0] sum32;

    int errors = 0;
    int checks = 0;
    logic both_seen = 1'b0;

    adder_nbit_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .carry_in(carry_in), .sub(sub), .busy(busy), .done(done),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    adder_nbit_seq #(.WIDTH(32), .CHUNK(8)) dut_w8 (
        .clk(clk), .rst(rst), .start(start8), .a(a32), .b(b32),
        .carry_in(cin32), .sub(sub32), .busy(busy8), .done(done8),
        .sum(sum8), .carry_out(co8), .overflow(ov8)
    );

    adder_nbit_seq #(.WIDTH(32), .CHUNK(32)) dut_w32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .carry_in(cin32), .sub(sub32), .busy(busy32), .done(done32),
        .sum(sum32), .carry_out(co32), .overflow(ov32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if ((busy && done) || (busy8 && done8) || (busy32 && done32)) both_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge and wait (bounded) for done; lat counts edges from E0.
    task automatic run16(input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, output int lat);
        a = av; b = bv; carry_in = ci; sub = sb; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 16'h0000)   begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", carry_out); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_add_basic();
        int lat;
        a = 16'h0000; b = 16'h0000; carry_in = 1'b1; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_after_start got=%b exp=0", done); end
        lat = 1;
        while (done !== 1'b1 && lat < 30) begin step(); lat++; end
        checks++; if (lat != 5)           begin errors++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++; if (sum !== 16'h0001)   begin errors++; $display("FAIL basic_sum got=%h exp=0001", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", carry_out); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL basic_ovf got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
        step();
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL basic_done_one_cycle got=%b exp=0", done); end
    endtask

    task automatic test_add_carry();
        int lat;
        run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat);
        checks++; if (lat != 5)           begin errors++; $display("FAIL cmax_latency got=%0d exp=5", lat); end
        checks++; if (sum !== 16'hFFFF)   begin errors++; $display("FAIL cmax_sum got=%h exp=ffff", sum); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL cmax_cout got=%b exp=1", carry_out); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL cmax_ovf got=%b exp=0", overflow); end
        step();
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        checks++; if (sum !== 16'h8000)   begin errors++; $display("FAIL povf_sum got=%h exp=8000", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL povf_cout got=%b exp=0", carry_out); end
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL povf_ovf got=%b exp=1", overflow); end
        step();
    endtask

    task automatic test_sub();
        int lat;
        run16(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        checks++; if (lat != 5)           begin errors++; $display("FAIL sub_latency got=%0d exp=5", lat); end
        checks++; if (sum !== 16'hFFFE)   begin errors++; $display("FAIL sub_borrow_sum got=%h exp=fffe", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got=%b exp=0", carry_out); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL sub_borrow_ovf got=%b exp=0", overflow); end
        step();
        run16(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
        checks++; if (sum !== 16'h7FFF)   begin errors++; $display("FAIL sub_ovf_sum got=%h exp=7fff", sum); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL sub_ovf_cout got=%b exp=1", carry_out); end
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL sub_ovf_ovf got=%b exp=1", overflow); end
        // Result must hold while idle, regardless of input activity.
        a = 16'h1111; b = 16'h2222; sub = 1'b0;
        step(); step(); step();
        checks++; if (sum !== 16'h7FFF)   begin errors++; $display("FAIL hold_sum got=%h exp=7fff", sum); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL hold_done got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        int npulse = 0;
        int last_cyc = 0;
        a = 16'd10000; b = 16'h24F8; carry_in = 1'b1; sub = 1'b0; start = 1'b1;
        step();
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (done === 1'b1) begin
                npulse++;
                checks++; if (sum !== 16'h4C09) begin errors++; $display("FAIL b2b_sum cyc=%0d got=%h exp=4c09", cyc, sum); end
                if (npulse > 1) begin
                    checks++; if (cyc - last_cyc != 5) begin errors++; $display("FAIL b2b_period got=%0d exp=5", cyc - last_cyc); end
                end
                last_cyc = cyc;
                a = 16'd10000; b = 16'h24F8; carry_in = 1'b1; sub = 1'b0;
                if (cyc == 15) start = 1'b0;
            end else begin
                a = 16'hFFFF; b = 16'hA5A5; carry_in = 1'b0; sub = 1'b1;
            end
            step();
        end
        start = 1'b0; sub = 1'b0;
        checks++; if (npulse != 3) begin errors++; $display("FAIL b2b_pulses got=%0d exp=3", npulse); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int ndone = 0;
        int lat;
        a = 16'h0001; b = 16'h0002; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_stray_done got=%0d exp=0", ndone); end
        run16(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
        checks++; if (lat != 5)         begin errors++; $display("FAIL midrst_after_latency got=%0d exp=5", lat); end
        checks++; if (sum !== 16'h2345) begin errors++; $display("FAIL midrst_after_sum got=%h exp=2345", sum); end
        step();
    endtask

    task automatic test_wide();
        int lat;
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b0; sub32 = 1'b0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 30) begin step(); lat++; end
        checks++; if (lat != 5)          begin errors++; $display("FAIL w8_latency got=%0d exp=5", lat); end
        checks++; if (sum8 !== 32'h0)    begin errors++; $display("FAIL w8_sum got=%h exp=00000000", sum8); end
        checks++; if (co8 !== 1'b1)      begin errors++; $display("FAIL w8_cout got=%b exp=1", co8); end
        checks++; if (ov8 !== 1'b0)      begin errors++; $display("FAIL w8_ovf got=%b exp=0", ov8); end
        step();
        start32 = 1'b1;
        step();
        start32 = 1'b0;
        lat = 1;
        while (done32 !== 1'b1 && lat < 30) begin step(); lat++; end
        checks++; if (lat != 2)          begin errors++; $display("FAIL w32_latency got=%0d exp=2", lat); end
        checks++; if (sum32 !== 32'h0)   begin errors++; $display("FAIL w32_sum got=%h exp=00000000", sum32); end
        checks++; if (co32 !== 1'b1)     begin errors++; $display("FAIL w32_cout got=%b exp=1", co32); end
        checks++; if (ov32 !== 1'b0)     begin errors++; $display("FAIL w32_ovf got=%b exp=0", ov32); end
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        start8 = 1'b0; start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_wide();
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL busy_and_done_together got=%b exp=0", both_seen); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
